// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C control-port master.
// Status codes, FSM states and quarter-phase encodings.
package i2c_pkg;

   localparam logic [1:0] STS_IDLE = 2'b00;
   localparam logic [1:0] STS_BUSY = 2'b01;
   localparam logic [1:0] STS_OK   = 2'b10;
   localparam logic [1:0] STS_NACK = 2'b11;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BIT,
      S_ACK,
      S_RSTART,
      S_STOP,
      S_DONE
   } state_e;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator.
// Emits one tick every CLK_DIV clocks while enabled; held at zero otherwise.
module i2c_tick_gen #(
   parameter int CLK_DIV = 125
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = en_i && (cnt_q == W'(CLK_DIV - 1));
      cnt_d  = cnt_q + 1'b1;
      if (!en_i || tick_o) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/i2c_master.sv
// Single-byte write / read I2C master driven by register-file fields.
// Bus outputs are registered so SCL/SDA never glitch on state decode.
module i2c_master
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 125
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i2c_go,
   input  logic [7:0] i2c_slave_addr,
   input  logic [8:0] i2c_addr,
   input  logic [7:0] reg_file_to_i2c_data,
   output logic       i2c_wr_en,
   output logic [1:0] i2c_sts,
   output logic [7:0] i2c_to_reg_file_data,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in
);

   state_e     state_q, state_d;
   logic [1:0] sync_q;
   logic [1:0] ph_q, ph_d;
   logic [1:0] step_q, step_d;
   logic [1:0] sts_q, sts_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] sub_q, sub_d;
   logic [7:0] wdat_q, wdat_d;
   logic [7:0] data_q, data_d;
   logic [6:0] addr_q, addr_d;
   logic       rw_q, rw_d;
   logic       nack_q, nack_d;
   logic       wr_en_q, wr_en_d;
   logic       scl_q, scl_d;
   logic       sda_q, sda_d;
   logic       tick, sda_s, rx, slot_scl;
   logic       unused_addr8;

   assign unused_addr8 = i2c_addr[8];
   assign sda_s        = sync_q[1];
   // step 3 is the byte clocked in from the slave
   assign rx           = (step_q == 2'd3);
   assign slot_scl     = (ph_q == Q0) || (ph_q == Q3);

   i2c_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .en_i  (state_q != S_IDLE),
      .tick_o(tick)
   );

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      step_d  = step_q;
      sts_d   = sts_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      sub_d   = sub_q;
      wdat_d  = wdat_q;
      data_d  = data_q;
      addr_d  = addr_q;
      rw_d    = rw_q;
      nack_d  = nack_q;
      wr_en_d = 1'b0;
      scl_d   = 1'b0;
      sda_d   = 1'b0;
      if (tick) ph_d = ph_q + 2'd1;

      case (state_q)
         S_IDLE: begin
            ph_d = Q0;
            if (i2c_go) begin
               addr_d  = i2c_slave_addr[7:1];
               rw_d    = i2c_slave_addr[0];
               sub_d   = i2c_addr[7:0];
               wdat_d  = reg_file_to_i2c_data;
               sh_d    = {i2c_slave_addr[7:1], 1'b0};
               step_d  = 2'd0;
               bit_d   = 3'd0;
               nack_d  = 1'b0;
               sts_d   = STS_BUSY;
               wr_en_d = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            scl_d = (ph_q == Q3);
            sda_d = (ph_q != Q0);
            if (tick && ph_q == Q3) state_d = S_BIT;
         end
         S_BIT: begin
            scl_d = slot_scl;
            sda_d = !rx && !sh_q[7];
            if (tick) begin
               if (rx && ph_q == Q2) sh_d = {sh_q[6:0], sda_s};
               if (ph_q == Q3) begin
                  if (!rx) sh_d = {sh_q[6:0], 1'b0};
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = S_ACK;
               end
            end
         end
         S_ACK: begin
            scl_d = slot_scl;
            if (tick && ph_q == Q2 && !rx) nack_d = sda_s;
            if (tick && ph_q == Q3) begin
               if (nack_q || rx) begin
                  state_d = S_STOP;
               end else begin
                  case (step_q)
                     2'd0: begin
                        sh_d    = sub_q;
                        step_d  = 2'd1;
                        state_d = S_BIT;
                     end
                     2'd1: begin
                        step_d = 2'd2;
                        if (rw_q) begin
                           state_d = S_RSTART;
                        end else begin
                           sh_d    = wdat_q;
                           state_d = S_BIT;
                        end
                     end
                     default: begin
                        if (rw_q) begin
                           step_d  = 2'd3;
                           state_d = S_BIT;
                        end else begin
                           state_d = S_STOP;
                        end
                     end
                  endcase
               end
            end
         end
         S_RSTART: begin
            scl_d = slot_scl;
            sda_d = ph_q[1];
            if (tick && ph_q == Q3) begin
               sh_d    = {addr_q, 1'b1};
               state_d = S_BIT;
            end
         end
         S_STOP: begin
            scl_d = (ph_q == Q0);
            sda_d = !ph_q[1];
            if (tick && ph_q == Q3) state_d = S_DONE;
         end
         S_DONE: begin
            wr_en_d = 1'b1;
            sts_d   = nack_q ? STS_NACK : STS_OK;
            if (rw_q && !nack_q) data_d = sh_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sync_q  <= 2'b11;
         ph_q    <= Q0;
         step_q  <= 2'd0;
         sts_q   <= STS_IDLE;
         bit_q   <= 3'd0;
         sh_q    <= 8'h00;
         sub_q   <= 8'h00;
         wdat_q  <= 8'h00;
         data_q  <= 8'h00;
         addr_q  <= 7'h00;
         rw_q    <= 1'b0;
         nack_q  <= 1'b0;
         wr_en_q <= 1'b0;
         scl_q   <= 1'b0;
         sda_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], sda_in};
         ph_q    <= ph_d;
         step_q  <= step_d;
         sts_q   <= sts_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         sub_q   <= sub_d;
         wdat_q  <= wdat_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         nack_q  <= nack_d;
         wr_en_q <= wr_en_d;
         scl_q   <= scl_d;
         sda_q   <= sda_d;
      end
   end

   assign i2c_wr_en            = wr_en_q;
   assign i2c_sts              = sts_q;
   assign i2c_to_reg_file_data = data_q;
   assign scl_oe               = scl_q;
   assign sda_oe               = sda_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: open-drain bus with pull-ups and a
// behavioural slave at 7-bit address 0x1A that returns 0x5C on reads.
module tb_i2c_master;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       go = 1'b0;
   logic [7:0] sa = 8'h00;
   logic [8:0] ad = 9'h000;
   logic [7:0] wd = 8'h00;
   logic       wr_en;
   logic [1:0] sts;
   logic [7:0] rdat;
   logic       scl_oe, sda_oe;
   logic       s_oe = 1'b0;
   logic       scl, sda;

   int errors = 0;
   int checks = 0;

   assign scl = ~scl_oe;
   assign sda = ~(sda_oe | s_oe);

   always #5 clk = ~clk;

   i2c_master #(
      .CLK_DIV(CLK_DIV)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .i2c_go              (go),
      .i2c_slave_addr      (sa),
      .i2c_addr            (ad),
      .reg_file_to_i2c_data(wd),
      .i2c_wr_en           (wr_en),
      .i2c_sts             (sts),
      .i2c_to_reg_file_data(rdat),
      .scl_oe              (scl_oe),
      .sda_oe              (sda_oe),
      .sda_in              (sda)
   );

   typedef enum int {M_IDLE, M_RX, M_ACK, M_TX, M_MACK, M_IGN} smode_e;

   smode_e     mode = M_IDLE;
   logic [7:0] rxlog[$];
   logic [7:0] shr = 8'h00;
   logic [7:0] txb = 8'h5C;
   logic       scl_p = 1'b1, sda_p = 1'b1, clr = 1'b0, clr_p = 1'b0;
   logic       first = 1'b0, rdmode = 1'b0, mack = 1'b0;
   int         bcnt = 0, txc = 0, nstart = 0, nstop = 0;

   // Slave: all bus reactions in one process, edges found against last values
   always @(scl or sda or clr) begin
      if (clr !== clr_p) begin
         rxlog.delete();
         nstart = 0;
         nstop  = 0;
         mode   = M_IDLE;
         s_oe   = 1'b0;
         mack   = 1'b0;
      end else if (sda !== sda_p && scl_p === 1'b1 && scl === 1'b1) begin
         if (sda === 1'b0) begin
            nstart++;
            mode  = M_RX;
            bcnt  = 0;
            first = 1'b1;
         end else begin
            nstop++;
            mode = M_IDLE;
            s_oe = 1'b0;
         end
      end else if (scl === 1'b1 && scl_p === 1'b0) begin
         if (mode == M_RX) begin
            shr = {shr[6:0], sda};
            bcnt++;
         end else if (mode == M_MACK) begin
            mack = sda;
         end
      end else if (scl === 1'b0 && scl_p === 1'b1) begin
         case (mode)
            M_RX: if (bcnt == 8) begin
               rxlog.push_back(shr);
               if (first && shr[7:1] != 7'h1A) begin
                  mode = M_IGN;
               end else begin
                  if (first) rdmode = shr[0];
                  s_oe = 1'b1;
                  mode = M_ACK;
               end
            end
            M_ACK: begin
               s_oe = 1'b0;
               if (first && rdmode) begin
                  txb  = 8'h5C;
                  s_oe = ~txb[7];
                  txc  = 1;
                  mode = M_TX;
               end else begin
                  bcnt = 0;
                  mode = M_RX;
               end
               first = 1'b0;
            end
            M_TX: if (txc < 8) begin
               s_oe = ~txb[7-txc];
               txc++;
            end else begin
               s_oe = 1'b0;
               mode = M_MACK;
            end
            M_MACK: mode = M_IGN;
            default: ;
         endcase
      end
      scl_p = scl;
      sda_p = sda;
      clr_p = clr;
   end

   task automatic slave_clear;
      clr = ~clr;
      #1;
   endtask

   task automatic run_txn(input logic [7:0] a, input logic [8:0] s,
                          input logic [7:0] d, input int busy_at,
                          input int tail, input bit now,
                          output int np, output logic [1:0] st1,
                          output logic [1:0] st2, output int dt);
      int after;
      np = 0; st1 = 2'bxx; st2 = 2'bxx; dt = -1; after = 0;
      if (!now) begin
         @(posedge clk); #1;
      end
      sa = a; ad = s; wd = d; go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
         end
         go = (cyc == busy_at);
         if (wr_en === 1'b1) begin
            np++;
            if (np == 1) st1 = sts;
            if (np == 2) begin
               st2 = sts;
               dt  = cyc;
            end
         end
         if (np >= 2) begin
            if (after >= tail) break;
            after++;
         end
      end
      go = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL reset_scl: got %b want 0", scl_oe); end
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda: got %b want 0", sda_oe); end
      checks++; if (sts !== 2'b00) begin errors++; $display("FAIL reset_sts: got %b want 00", sts); end
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
      checks++; if (rdat !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rdat); end
      rst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_write;
      int np, dt;
      logic [1:0] s1, s2;
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'h34, 8'h0F, 8'hA5};
      slave_clear;
      run_txn(8'h34, 9'h00F, 8'hA5, -1, 20, 1'b0, np, s1, s2, dt);
      checks++; if (np !== 2) begin errors++; $display("FAIL write_pulses: got %0d want 2", np); end
      checks++; if (s1 !== 2'b01) begin errors++; $display("FAIL write_sts1: got %b want 01", s1); end
      checks++; if (s2 !== 2'b10) begin errors++; $display("FAIL write_sts2: got %b want 10", s2); end
      checks++; if (dt < 460 || dt > 468) begin errors++; $display("FAIL write_time: got %0d want 464+-4", dt); end
      checks++; if (rxlog.size() !== 3) begin errors++; $display("FAIL write_nbytes: got %0d want 3", rxlog.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < rxlog.size()) ? rxlog[i] : 8'hxx;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL write_byte%0d: got %h want %h", i, got, exp[i]); end
      end
      checks++; if (nstart !== 1 || nstop !== 1) begin errors++; $display("FAIL write_framing: got S=%0d P=%0d want 1 1", nstart, nstop); end
   endtask

   task automatic test_read;
      int np, dt;
      logic [1:0] s1, s2;
      logic [7:0] exp [3];
      logic [7:0] got;
      exp = '{8'h34, 8'h07, 8'h35};
      slave_clear;
      run_txn(8'h35, 9'h107, 8'h00, -1, 5, 1'b0, np, s1, s2, dt);
      checks++; if (np !== 2) begin errors++; $display("FAIL read_pulses: got %0d want 2", np); end
      checks++; if (s2 !== 2'b10) begin errors++; $display("FAIL read_sts: got %b want 10", s2); end
      checks++; if (rdat !== 8'h5C) begin errors++; $display("FAIL read_data: got %h want 5c", rdat); end
      checks++; if (rxlog.size() !== 3) begin errors++; $display("FAIL read_nbytes: got %0d want 3", rxlog.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < rxlog.size()) ? rxlog[i] : 8'hxx;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL read_byte%0d: got %h want %h", i, got, exp[i]); end
      end
      checks++; if (nstart !== 2 || nstop !== 1) begin errors++; $display("FAIL read_framing: got S=%0d P=%0d want 2 1", nstart, nstop); end
      checks++; if (mack !== 1'b1) begin errors++; $display("FAIL read_master_nack: got %b want 1", mack); end
   endtask

   task automatic test_nack;
      int np, dt;
      logic [1:0] s1, s2;
      slave_clear;
      run_txn(8'h40, 9'h011, 8'h22, -1, 5, 1'b0, np, s1, s2, dt);
      checks++; if (s2 !== 2'b11) begin errors++; $display("FAIL nack_sts: got %b want 11", s2); end
      checks++; if (rdat !== 8'h5C) begin errors++; $display("FAIL nack_data: got %h want 5c", rdat); end
      checks++; if (rxlog.size() !== 1) begin errors++; $display("FAIL nack_nbytes: got %0d want 1", rxlog.size()); end
      checks++; if (nstop !== 1) begin errors++; $display("FAIL nack_stop: got %0d want 1", nstop); end
      checks++; if (dt < 173 || dt > 181) begin errors++; $display("FAIL nack_time: got %0d want 177+-4", dt); end
   endtask

   task automatic test_go_busy;
      int np, dt;
      logic [1:0] s1, s2;
      slave_clear;
      run_txn(8'h34, 9'h033, 8'h44, 50, 600, 1'b0, np, s1, s2, dt);
      checks++; if (np !== 2) begin errors++; $display("FAIL busy_pulses: got %0d want 2", np); end
      checks++; if (s2 !== 2'b10) begin errors++; $display("FAIL busy_sts: got %b want 10", s2); end
      checks++; if (rxlog.size() !== 3 || nstart !== 1) begin errors++; $display("FAIL busy_txn: got bytes=%0d S=%0d want 3 1", rxlog.size(), nstart); end
   endtask

   task automatic test_reset_mid;
      int np, dt;
      logic [1:0] s1, s2;
      slave_clear;
      @(posedge clk); #1;
      sa = 8'h34; ad = 9'h0AA; wd = 8'h55; go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      repeat (200) @(posedge clk);
      #4 rst = 1'b0;
      #1;
      checks++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_bus: got scl_oe=%b sda_oe=%b want 0 0", scl_oe, sda_oe); end
      checks++; if (sts !== 2'b00) begin errors++; $display("FAIL rstmid_sts: got %b want 00", sts); end
      checks++; if (rdat !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", rdat); end
      #3 rst = 1'b1;
      slave_clear;
      run_txn(8'h34, 9'h066, 8'h77, -1, 5, 1'b0, np, s1, s2, dt);
      checks++; if (s2 !== 2'b10) begin errors++; $display("FAIL rstmid_after_sts: got %b want 10", s2); end
      checks++; if (rxlog.size() !== 3 || (rxlog.size() == 3 && rxlog[2] !== 8'h77)) begin errors++; $display("FAIL rstmid_after_bytes: got n=%0d want 3 ending 77", rxlog.size()); end
   endtask

   task automatic test_back_to_back;
      int np1, np2, dt;
      logic [1:0] a1, a2, b1, b2;
      logic [7:0] exp [6];
      logic [7:0] got;
      exp = '{8'h34, 8'h01, 8'h11, 8'h34, 8'h02, 8'h22};
      slave_clear;
      run_txn(8'h34, 9'h001, 8'h11, -1, 0, 1'b0, np1, a1, a2, dt);
      run_txn(8'h34, 9'h002, 8'h22, -1, 5, 1'b1, np2, b1, b2, dt);
      checks++; if (a2 !== 2'b10) begin errors++; $display("FAIL b2b_first_sts: got %b want 10", a2); end
      checks++; if (np2 !== 2 || b1 !== 2'b01) begin errors++; $display("FAIL b2b_accept: got pulses=%0d sts=%b want 2 01", np2, b1); end
      checks++; if (b2 !== 2'b10) begin errors++; $display("FAIL b2b_second_sts: got %b want 10", b2); end
      checks++; if (rxlog.size() !== 6) begin errors++; $display("FAIL b2b_nbytes: got %0d want 6", rxlog.size()); end
      for (int i = 0; i < 6; i++) begin
         got = (i < rxlog.size()) ? rxlog[i] : 8'hxx;
         checks++; if (got !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp[i]); end
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_nack;
      test_go_busy;
      test_reset_mid;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Register-file-driven I2C master that runs the codec control-port transactions described by the I2C fields of the register file.
- On a go pulse it latches the slave address, sub-address and write data. It then performs one single-byte write or one single-byte read (sub-address write followed by a repeated START).
- It returns a status code, and read data when applicable, through a one-cycle write-enable pulse.
- It sits between the register file and open-drain SCL/SDA pads at the top level.

Parameters:
- CLK_DIV, 125, system clocks per quarter SCL period (50 MHz / (4*125) = 100 kHz); legal range 2..4095.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i2c_go  in  1  one-cycle start request
- i2c_slave_addr  in  8  [7:1] 7-bit slave address, [0] R/W (1 = read)
- i2c_addr  in  9  [7:0] sub-address; [8] ignored (shared with status field)
- reg_file_to_i2c_data  in  8  write data byte
- i2c_wr_en  out  1  one-cycle pulse: register file latches i2c_sts and i2c_to_reg_file_data
- i2c_sts  out  2  00 idle, 01 busy, 10 done-ok, 11 done-nack
- i2c_to_reg_file_data  out  8  last byte read from the slave
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low
- sda_in  in  1  SDA pad input, asynchronous

Behaviour:
- Reset (asynchronous, rst=0):
  - FSM goes to IDLE; scl_oe=0 and sda_oe=0 (bus released).
  - i2c_sts=00, i2c_wr_en=0, i2c_to_reg_file_data=0, tick counter cleared.
  - Reset mid-transaction aborts immediately with the bus released; no STOP is generated.
- sda_in passes through a 2-flop synchroniser before use.
- Tick generator: a one-cycle tick every CLK_DIV clocks, running only while not IDLE. Every bus symbol is 4 ticks (q0..q3).
- Go handling:
  - i2c_go in IDLE latches all three inputs.
  - i2c_sts becomes 01 and i2c_wr_en pulses, both in the cycle after go.
  - i2c_go outside IDLE is ignored.
- FSM states: IDLE, START, BIT, ACK, RSTART, STOP, DONE.
  - START: q0 both released; q1 SDA low; q2 SDA low; q3 SCL low.
  - BIT: MSB first, 8 slots.
    - Each slot: q0 SCL low with SDA set (transmit) or released (receive); q1 SCL released; q2 SCL high; q3 SCL low.
    - Receive samples the synchronised SDA at the q2 tick.
  - ACK, transmit byte: SDA released; sample at q2; 1 = NACK.
  - ACK, receive byte: master drives NACK (SDA released).
  - RSTART: q0 SDA released with SCL low; q1 SCL released; q2 SDA low; q3 SCL low.
  - STOP: q0 SDA low with SCL low; q1 SCL released; q2 SDA released; q3 idle.
- Write sequence (R/W=0): START, {addr,0}, ACK, sub, ACK, data, ACK, STOP. Total 116 ticks.
- Read sequence (R/W=1): START, {addr,0}, ACK, sub, ACK, RSTART, {addr,1}, ACK, 8 receive bits, master NACK, STOP.
- NACK on any transmitted byte: go straight to STOP; final status 11; remaining bytes are not sent.
- DONE (lasts 1 cycle):
  - i2c_sts becomes 10 or 11 and i2c_wr_en pulses.
  - i2c_to_reg_file_data updates only on a successful read; otherwise it holds its previous value.
  - Next cycle returns to IDLE; i2c_sts holds its value until the next go.
- i2c_go in the same cycle as DONE is ignored; go is accepted from IDLE only.
- No clock stretching and no arbitration (single-master bus).

Decomposition:
- Package i2c_pkg:
  - Status constants STS_IDLE, STS_BUSY, STS_OK, STS_NACK.
  - FSM state enum.
  - Quarter-phase constants Q0..Q3.
- Sub-module i2c_tick_gen: counter of width clog2(CLK_DIV); enable in, tick out.
- Main module holds the FSM, shift register, bit counter and phase counter.

Test Plan (CLK_DIV=4, open-drain bus model with pull-ups, slave model at 0x1A):
- Write: slave_addr=0x34, addr=0x0F, data=0xA5, go.
  - Slave receives bytes 0x34, 0x0F, 0xA5, each ACKed, then START...STOP.
  - i2c_wr_en pulses twice: sts 01, then 10 after 116*4 cycles (±4).
- Read: slave_addr=0x35, addr=0x07; slave returns 0x5C.
  - Bus shows 0x34, 0x07, repeated START, 0x35, then master NACK and STOP.
  - sts=10 and i2c_to_reg_file_data=0x5C on the final pulse.
- NACK: slave_addr=0x40 (no slave present).
  - Only the first byte is sent, then STOP.
  - sts=11; i2c_to_reg_file_data unchanged.
- Go while busy: second go 50 cycles into a write.
  - Ignored: exactly one transaction and two i2c_wr_en pulses.
- Reset mid-byte: rst low during the second byte.
  - scl_oe=0, sda_oe=0 and sts=00 immediately, with no clock edge needed.
  - After release, a new write completes with sts=10.
- Back-to-back: go in the cycle after the DONE pulse.
  - Accepted; the second write completes correctly.
